// File: rtl/whistle_command_decoder.sv
// whistle_command_decoder: groups whistle-detect pulses into timed whistles and sequences,
// then emits one command code per sequence classified by the pitch of its first whistle.
module whistle_command_decoder #(
    parameter int BIN_W         = 8,
    parameter int TICK_DIV      = 50000,
    parameter int MIN_ON_TICKS  = 100,
    parameter int RELEASE_TICKS = 50,
    parameter int GAP_TICKS     = 600,
    parameter int MAX_COUNT     = 3,
    parameter int SPLIT_BIN     = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             whistle_pulse,
    input  logic [BIN_W-1:0] pitch_bin,
    input  logic             pitch_valid,
    output logic             cmd_valid,
    output logic [3:0]       cmd_code,
    output logic             whistle_active,
    output logic             busy
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int OW = $clog2(MIN_ON_TICKS + 1);
    localparam int RW = $clog2(RELEASE_TICKS + 1);
    localparam int GW = $clog2(GAP_TICKS + 1);

    typedef enum logic [1:0] {IDLE, ON, GAP, EMIT} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    pre;
    logic [OW-1:0]    on_cnt;
    logic [RW-1:0]    rel_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [2:0]       count, count_inc;
    logic [BIN_W-1:0] last_bin;
    logic             cls, tick, expire;

    always_comb begin
        tick           = pre == PW'(TICK_DIV - 1);
        expire         = state == ON && !whistle_pulse && rel_cnt == '0;
        count_inc      = (on_cnt >= OW'(MIN_ON_TICKS) && count != 3'(MAX_COUNT)) ? count + 3'd1 : count;
        whistle_active = state == ON;
        busy           = state != IDLE;
        state_n        = state;
        case (state)
            IDLE:    state_n = whistle_pulse ? ON : IDLE;
            ON:      state_n = expire ? (count_inc == 3'd0 ? IDLE : GAP) : ON;
            GAP:     state_n = whistle_pulse ? ON : (gap_cnt == GW'(GAP_TICKS) ? EMIT : GAP);
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre       <= '0;
            last_bin  <= '0;
            on_cnt    <= '0;
            rel_cnt   <= '0;
            gap_cnt   <= '0;
            count     <= '0;
            cls       <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
        end else begin
            pre     <= tick ? '0 : pre + 1'b1;
            if (pitch_valid)
                last_bin <= pitch_bin;
            on_cnt  <= state != ON ? '0 : (tick && on_cnt != OW'(MIN_ON_TICKS)) ? on_cnt + 1'b1 : on_cnt;
            rel_cnt <= (whistle_pulse || state != ON) ? RW'(RELEASE_TICKS) :
                       (tick && rel_cnt != '0) ? rel_cnt - 1'b1 : rel_cnt;
            // gap_cnt is held at zero outside GAP so a glitch mid-sequence restarts the gap
            gap_cnt <= state != GAP ? '0 : (tick && gap_cnt != GW'(GAP_TICKS)) ? gap_cnt + 1'b1 : gap_cnt;
            count   <= state == EMIT ? 3'd0 : expire ? count_inc : count;
            cls     <= state == EMIT ? 1'b0 :
                       (state == IDLE && whistle_pulse && count == 3'd0) ?
                       (pitch_valid ? pitch_bin >= BIN_W'(SPLIT_BIN) : last_bin >= BIN_W'(SPLIT_BIN)) : cls;
            cmd_valid <= state_n == EMIT;
            if (state_n == EMIT)
                cmd_code <= {cls, count};
        end
    end
endmodule

// File: tb/tb_whistle_command_decoder.sv
// tb_whistle_command_decoder: table-driven sequences plus hand-written glitch, reset and
// gap-expiry coincidence cases, using short timing parameters.
module tb_whistle_command_decoder;
    logic       clk = 1'b0, reset_n = 1'b0, whistle_pulse = 1'b0, pitch_valid = 1'b0;
    logic [7:0] pitch_bin = '0;
    logic       cmd_valid, whistle_active, busy;
    logic [3:0] cmd_code, last_code = '0;
    logic       prev_valid = 1'b0;
    int tests = 0, fails = 0, strobes = 0, active_cyc = 0, cyc = 0, strobe_cyc = 0, last_pulse = 0;

    typedef struct {
        logic [7:0] bin;
        logic [7:0] bin2;
        int         nwh;
        bit         same;
        logic [3:0] code;
    } vec_t;
    vec_t vt[8];

    whistle_command_decoder #(
        .BIN_W(8), .TICK_DIV(10), .MIN_ON_TICKS(4), .RELEASE_TICKS(2),
        .GAP_TICKS(6), .MAX_COUNT(3), .SPLIT_BIN(64)
    ) dut (
        .clk(clk), .reset_n(reset_n), .whistle_pulse(whistle_pulse), .pitch_bin(pitch_bin),
        .pitch_valid(pitch_valid), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .whistle_active(whistle_active), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    always @(negedge clk) begin
        if (prev_valid) begin
            check("busy_after_emit", busy, 0);
            check("valid_single_cycle", cmd_valid, 0);
        end
        prev_valid = cmd_valid;
        if (cmd_valid) begin
            strobes++;
            last_code = cmd_code;
            strobe_cyc = cyc;
        end
        if (whistle_active) active_cyc++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_bin(input logic [7:0] b);
        pitch_valid = 1'b1;
        pitch_bin = b;
        @(negedge clk);
        pitch_valid = 1'b0;
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) begin
            whistle_pulse = 1'b1;
            last_pulse = cyc;
            @(negedge clk);
            whistle_pulse = 1'b0;
            idle(9);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    initial begin
        vt[0] = '{8'd80, 8'd80, 1, 1'b0, 4'b1001};
        vt[1] = '{8'd30, 8'd30, 2, 1'b0, 4'b0010};
        vt[2] = '{8'd80, 8'd80, 5, 1'b0, 4'b1011};
        vt[3] = '{8'd30, 8'd30, 3, 1'b0, 4'b0011};
        vt[4] = '{8'd64, 8'd64, 1, 1'b0, 4'b1001};
        vt[5] = '{8'd63, 8'd63, 1, 1'b0, 4'b0001};
        vt[6] = '{8'd30, 8'd80, 2, 1'b0, 4'b0010};
        vt[7] = '{8'd90, 8'd90, 2, 1'b1, 4'b1010};

        idle(3);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_code", cmd_code, 0);
        check("rst_active", whistle_active, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        idle(5);

        for (int v = 0; v < 8; v++) begin
            strobes = 0;
            if (vt[v].same) begin
                set_bin(vt[v].bin >= 8'd64 ? 8'd10 : 8'd100);
                whistle_pulse = 1'b1;
                pitch_valid = 1'b1;
                pitch_bin = vt[v].bin;
                @(negedge clk);
                whistle_pulse = 1'b0;
                pitch_valid = 1'b0;
                idle(9);
                burst(7);
            end else begin
                set_bin(vt[v].bin);
                burst(8);
            end
            for (int w = 1; w < vt[v].nwh; w++) begin
                idle(30);
                check("no_strobe_between", strobes, 0);
                set_bin(vt[v].bin2);
                burst(8);
            end
            wait_idle(300);
            check("strobe_count", strobes, 1);
            check("cmd_code", last_code, vt[v].code);
            check_rng("emit_latency", strobe_cyc - last_pulse, 55, 95);
            idle(5);
        end

        // single glitch from IDLE
        strobes = 0;
        active_cyc = 0;
        whistle_pulse = 1'b1;
        @(negedge clk);
        whistle_pulse = 1'b0;
        wait_idle(30);
        check_rng("glitch_active_cycles", active_cyc, 10, 22);
        idle(100);
        check("glitch_no_strobe", strobes, 0);

        // asynchronous reset while in GAP
        set_bin(8'd80);
        burst(8);
        idle(20);
        check("pre_reset_busy", busy, 1);
        check("pre_reset_gap", whistle_active, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", cmd_valid, 0);
        check("async_rst_code", cmd_code, 0);
        check("async_rst_active", whistle_active, 0);
        check("async_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        strobes = 0;
        idle(200);
        check("post_reset_no_strobe", strobes, 0);
        check("post_reset_busy", busy, 0);

        // pulse lands in the exact cycle the gap expires
        set_bin(8'd80);
        burst(8);
        begin
            int n = 0;
            while (dut.gap_cnt != 3'd6 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("gap_expiry_reached", dut.gap_cnt, 6);
        end
        strobes = 0;
        burst(8);
        check("coincide_no_strobe", strobes, 0);
        wait_idle(300);
        check("coincide_strobes", strobes, 1);
        check("coincide_code", last_code, 4'b1010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
